// File: rtl/uart_serdes_pkg.sv
// Shared types and constants for the uart_serdes serial PHY.
// Optional even parity is enabled by defining UART_SERDES_PARITY_EN.
package uart_serdes_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam logic UART_STOP_LEVEL = 1'b1;

`ifdef UART_SERDES_PARITY_EN
  localparam int UART_PARITY_BITS = 1;
  localparam int UART_BIT_IDX_W = 4;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_t;
`else
  localparam int UART_BIT_IDX_W = 3;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;
`endif

endpackage

// File: rtl/uart_rx_deser.sv
// RX half of uart_serdes: 2-flop rxd synchroniser, mid-bit sampling FSM and
// shift register. Parity state present only with UART_SERDES_PARITY_EN.
module uart_rx_deser
  import uart_serdes_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rxd,
  output logic [UART_DATA_BITS-1:0] data,
  output logic                      done,
`ifdef UART_SERDES_PARITY_EN
  output logic                      parity_err,
`endif
  output logic                      frame_err
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [UART_BIT_IDX_W-1:0] IDX_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  logic                      sync1_q, sync1_d;
  logic                      rxs_q, rxs_d;
  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [UART_BIT_IDX_W-1:0] idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      done_q, done_d;
  logic                      ferr_q, ferr_d;
`ifdef UART_SERDES_PARITY_EN
  logic [UART_PARITY_BITS-1:0] par_bad_q, par_bad_d;
  logic                        perr_q, perr_d;
`endif

  always_comb begin
    sync1_d = rxd;
    rxs_d   = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_SERDES_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Half a bit in: a line back high means a glitch, not a start bit.
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          idx_d = '0;
          state_d = rxs_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs_q, shift_q[UART_DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
`ifdef UART_SERDES_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_SERDES_PARITY_EN
      RX_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          par_bad_d = rxs_q ^ (^shift_q);
          state_d   = RX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          ferr_d  = (rxs_q != UART_STOP_LEVEL);
`ifdef UART_SERDES_PARITY_EN
          perr_d  = par_bad_q[0];
          done_d  = (rxs_q == UART_STOP_LEVEL) && !par_bad_q[0];
`else
          done_d  = (rxs_q == UART_STOP_LEVEL);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_SERDES_PARITY_EN
      par_bad_q <= '0;
      perr_q    <= 1'b0;
`endif
    end else begin
      sync1_q <= sync1_d;
      rxs_q   <= rxs_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_SERDES_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data      = shift_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
`ifdef UART_SERDES_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: rtl/uart_serdes.sv
// 8N1 UART PHY between a valid/ready byte stream and the txd/rxd pins.
// Define UART_SERDES_PARITY_EN for an even-parity bit and rx_parity_err.
module uart_serdes
  import uart_serdes_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       txd,
  input  logic       rxd,
  output logic       rx_frame_err,
`ifdef UART_SERDES_PARITY_EN
  output logic       rx_parity_err,
`endif
  output logic       rx_overrun
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLK_DIV - 2);
  localparam logic [UART_BIT_IDX_W-1:0] IDX_LAST = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  tx_state_t                 tx_state_q, tx_state_d;
  logic [CW-1:0]             tx_cnt_q, tx_cnt_d;
  logic [UART_BIT_IDX_W-1:0] tx_idx_q, tx_idx_d;
  logic [UART_DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                      txd_q, txd_d;
`ifdef UART_SERDES_PARITY_EN
  logic [UART_PARITY_BITS-1:0] tx_par_q, tx_par_d;
`endif

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
`ifdef UART_SERDES_PARITY_EN
    tx_par_d   = tx_par_q;
`endif
    tx_ready   = (tx_state_q == TX_IDLE);
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = UART_STOP_LEVEL;
        if (tx_valid) begin
          tx_shift_d = tx_data;
`ifdef UART_SERDES_PARITY_EN
          tx_par_d   = ^tx_data;
`endif
          tx_cnt_d   = '0;
          txd_d      = 1'b0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          tx_idx_d   = '0;
          txd_d      = tx_shift_q[0];
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == IDX_LAST) begin
`ifdef UART_SERDES_PARITY_EN
            txd_d      = tx_par_q[0];
            tx_state_d = TX_PARITY;
`else
            txd_d      = UART_STOP_LEVEL;
            tx_state_d = TX_STOP;
`endif
          end else begin
            tx_idx_d   = tx_idx_q + 1'b1;
            tx_shift_d = {1'b0, tx_shift_q[UART_DATA_BITS-1:1]};
            txd_d      = tx_shift_q[1];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
`ifdef UART_SERDES_PARITY_EN
      TX_PARITY: begin
        if (tx_cnt_q == CNT_LAST) begin
          tx_cnt_d   = '0;
          txd_d      = UART_STOP_LEVEL;
          tx_state_d = TX_STOP;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
`endif
      TX_STOP: begin
        // Leave one cycle early: the IDLE cycle is the last stop-bit cycle.
        if (tx_cnt_q == STOP_LAST) begin
          tx_cnt_d   = '0;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
`ifdef UART_SERDES_PARITY_EN
      tx_par_q   <= '0;
`endif
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
`ifdef UART_SERDES_PARITY_EN
      tx_par_q   <= tx_par_d;
`endif
    end
  end

  assign txd = txd_q;

  logic [7:0] deser_data;
  logic       deser_done;

  uart_rx_deser #(.CLK_DIV(CLK_DIV)) u_rx_deser (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .data       (deser_data),
    .done       (deser_done),
`ifdef UART_SERDES_PARITY_EN
    .parity_err (rx_parity_err),
`endif
    .frame_err  (rx_frame_err)
  );

  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_overrun_q, rx_overrun_d;

  // Holding register: a new byte may replace one that is being consumed now.
  always_comb begin
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = 1'b0;
    if (deser_done) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = deser_data;
        rx_valid_d = 1'b1;
      end else begin
        rx_overrun_d = 1'b1;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_uart_serdes.sv
// Directed self-checking bench for uart_serdes at CLK_DIV=4; outputs are
// sampled on the falling edge, inputs driven just after it.
module tb_uart_serdes;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       txd;
  logic       rxd = 1'b1;
  logic       rx_frame_err;
  logic       rx_overrun;
`ifdef UART_SERDES_PARITY_EN
  logic       rx_parity_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  int         cnt_valid, cnt_ferr, cnt_ovr, stable_viol;
  logic [7:0] last_data;
  logic       prev_valid;
  logic [7:0] prev_data;

  always #5 clk = ~clk;

  uart_serdes #(.CLK_DIV(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .txd          (txd),
    .rxd          (rxd),
    .rx_frame_err (rx_frame_err),
`ifdef UART_SERDES_PARITY_EN
    .rx_parity_err(rx_parity_err),
`endif
    .rx_overrun   (rx_overrun)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr_counts();
    cnt_valid = 0; cnt_ferr = 0; cnt_ovr = 0; stable_viol = 0;
    last_data = 8'h00; prev_valid = 1'b0; prev_data = 8'h00;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rx_valid) begin
      cnt_valid++;
      last_data = rx_data;
      if (prev_valid && rx_data !== prev_data) stable_viol++;
    end
    if (rx_frame_err) cnt_ferr++;
    if (rx_overrun) cnt_ovr++;
    prev_valid = rx_valid;
    prev_data  = rx_data;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic stop_lvl);
    logic [9:0] fr;
    fr = {stop_lvl, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = fr[i];
      repeat (4) tick();
    end
    rxd = 1'b1;
    repeat (12) tick();
    $display("rx frame %h stop=%b: valid_cycles=%0d data=%h ferr=%0d ovr=%0d",
             b, stop_lvl, cnt_valid, last_data, cnt_ferr, cnt_ovr);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd got %b exp 1", txd); end
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    n_cmp++;
    if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    n_cmp++;
    if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err got %b exp 0", rx_frame_err); end
    n_cmp++;
    if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun got %b exp 0", rx_overrun); end
    n_cmp++;
    rst = 1'b0;
    tick();
    $display("reset checked");
  endtask

  task automatic test_tx_single();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL tx1_ready_pre got %b exp 1", tx_ready); end
    n_cmp++;
    for (int k = 1; k <= 41; k++) begin
      tick();
      if (k == 1) tx_valid = 1'b0;
      if (txd !== ((k <= 40) ? fr[(k-1)/4] : 1'b1)) begin
        n_bad++; $display("FAIL tx1_txd cycle %0d got %b exp %b", k, txd, (k <= 40) ? fr[(k-1)/4] : 1'b1);
      end
      n_cmp++;
      if (tx_ready !== (k >= 40)) begin
        n_bad++; $display("FAIL tx1_ready cycle %0d got %b exp %b", k, tx_ready, (k >= 40));
      end
      n_cmp++;
    end
    $display("tx byte a5 single frame done");
  endtask

  task automatic test_tx_back_to_back();
    logic [19:0] fr;
    fr = {1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0};
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    for (int k = 1; k <= 81; k++) begin
      tick();
      if (k == 1) tx_data = 8'hFF;
      if (k == 41) tx_valid = 1'b0;
      if (txd !== ((k <= 80) ? fr[(k-1)/4] : 1'b1)) begin
        n_bad++; $display("FAIL tx2_txd cycle %0d got %b exp %b", k, txd, (k <= 80) ? fr[(k-1)/4] : 1'b1);
      end
      n_cmp++;
      if (tx_ready !== (k == 40 || k >= 80)) begin
        n_bad++; $display("FAIL tx2_ready cycle %0d got %b exp %b", k, tx_ready, (k == 40 || k >= 80));
      end
      n_cmp++;
    end
    $display("tx bytes 00,ff back to back done");
  endtask

  task automatic test_reset_mid_frame();
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    if (txd !== 1'b0) begin n_bad++; $display("FAIL midrst_pre_txd got %b exp 0", txd); end
    n_cmp++;
    rst = 1'b1;
    tick();
    if (txd !== 1'b1) begin n_bad++; $display("FAIL midrst_txd got %b exp 1", txd); end
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready got %b exp 1", tx_ready); end
    n_cmp++;
    rst = 1'b0;
    repeat (2) tick();
    $display("tx reset mid-frame done");
  endtask

  task automatic test_rx_frame();
    rx_ready = 1'b1;
    clr_counts();
    rx_send(8'h3C, 1'b1);
    if (cnt_valid !== 1) begin n_bad++; $display("FAIL rx3_valid_cycles got %0d exp 1", cnt_valid); end
    n_cmp++;
    if (last_data !== 8'h3C) begin n_bad++; $display("FAIL rx3_data got %h exp 3c", last_data); end
    n_cmp++;
    if (cnt_ferr !== 0) begin n_bad++; $display("FAIL rx3_ferr got %0d exp 0", cnt_ferr); end
    n_cmp++;
    if (cnt_ovr !== 0) begin n_bad++; $display("FAIL rx3_ovr got %0d exp 0", cnt_ovr); end
    n_cmp++;
  endtask

  task automatic test_rx_glitch();
    rx_ready = 1'b1;
    clr_counts();
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (12) tick();
    $display("rx glitch: valid_cycles=%0d ferr=%0d", cnt_valid, cnt_ferr);
    if (cnt_valid !== 0) begin n_bad++; $display("FAIL rx4_glitch_valid got %0d exp 0", cnt_valid); end
    n_cmp++;
    if (cnt_ferr !== 0) begin n_bad++; $display("FAIL rx4_glitch_ferr got %0d exp 0", cnt_ferr); end
    n_cmp++;
    clr_counts();
    rx_send(8'h81, 1'b1);
    if (cnt_valid !== 1) begin n_bad++; $display("FAIL rx4_valid_cycles got %0d exp 1", cnt_valid); end
    n_cmp++;
    if (last_data !== 8'h81) begin n_bad++; $display("FAIL rx4_data got %h exp 81", last_data); end
    n_cmp++;
  endtask

  task automatic test_rx_frame_err();
    rx_ready = 1'b1;
    clr_counts();
    rx_send(8'h55, 1'b0);
    if (cnt_ferr !== 1) begin n_bad++; $display("FAIL rx5_ferr_cycles got %0d exp 1", cnt_ferr); end
    n_cmp++;
    if (cnt_valid !== 0) begin n_bad++; $display("FAIL rx5_valid got %0d exp 0", cnt_valid); end
    n_cmp++;
    if (cnt_ovr !== 0) begin n_bad++; $display("FAIL rx5_ovr got %0d exp 0", cnt_ovr); end
    n_cmp++;
  endtask

  task automatic test_rx_overrun();
    rx_ready = 1'b0;
    clr_counts();
    rx_send(8'h11, 1'b1);
    if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx6_first_valid got %b exp 1", rx_valid); end
    n_cmp++;
    if (rx_data !== 8'h11) begin n_bad++; $display("FAIL rx6_first_data got %h exp 11", rx_data); end
    n_cmp++;
    rx_send(8'h22, 1'b1);
    if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL rx6_held_valid got %b exp 1", rx_valid); end
    n_cmp++;
    if (rx_data !== 8'h11) begin n_bad++; $display("FAIL rx6_held_data got %h exp 11", rx_data); end
    n_cmp++;
    if (cnt_ovr !== 1) begin n_bad++; $display("FAIL rx6_overrun_cycles got %0d exp 1", cnt_ovr); end
    n_cmp++;
    if (stable_viol !== 0) begin n_bad++; $display("FAIL rx6_data_stable got %0d changes exp 0", stable_viol); end
    n_cmp++;
    if (cnt_ferr !== 0) begin n_bad++; $display("FAIL rx6_ferr got %0d exp 0", cnt_ferr); end
    n_cmp++;
    rx_ready = 1'b1;
    tick();
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL rx6_drop_valid got %b exp 0", rx_valid); end
    n_cmp++;
    if (rx_data !== 8'h11) begin n_bad++; $display("FAIL rx6_after_data got %h exp 11", rx_data); end
    n_cmp++;
    repeat (4) tick();
    if (cnt_valid - 1 !== 80) begin
      // valid stayed high from the first delivery until the handshake cycle
    end
    $display("rx overrun: read %h once, valid now %b", rx_data, rx_valid);
  endtask

  initial begin
    clr_counts();
    test_reset();
    test_tx_single();
    test_tx_back_to_back();
    test_reset_mid_frame();
    test_rx_frame();
    test_rx_glitch();
    test_rx_frame_err();
    test_rx_overrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
